// File: rtl/accumulator_arbiter.sv
// Round-robin arbiter that shares one serial accumulator among r requesters.
// A granted requester's k words are parked on acc_din, the accumulator is
// kicked with a single acc_pl pulse, and the returned sum is handed back
// with a one-cycle ack (or a one-cycle err if the accumulator never finishes).
// All outputs are registered. Decisions are made on the next state so that
// each output is valid in the same cycle as the state that owns it.
module accumulator_arbiter #(
    parameter int m       = 4,
    parameter int n       = 2,
    parameter int k       = 4,
    parameter int r       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [r-1:0]              req,
    input  logic [r*(m+n)*k-1:0]      req_data,
    output logic [r-1:0]              ack,
    output logic [r-1:0]              err,
    output logic [m+n+k-2:0]          result,
    output logic                      busy,
    output logic [$clog2(r)-1:0]      grant_id,
    output logic [(m+n)*k-1:0]        acc_din,
    output logic                      acc_pl,
    input  logic                      acc_ready,
    input  logic [m+n+k-2:0]          acc_sum
);

    localparam int WW = m + n;            // width of one input word
    localparam int DW = WW * k;           // width of one requester's job
    localparam int SW = m + n + k - 1;    // width of the accumulated sum
    localparam int GW = $clog2(r);        // width of a requester index
    localparam int CW = $clog2(TIMEOUT);  // holds 0 .. TIMEOUT-1

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WAIT_LO = 3'd2,
        S_WAIT_HI = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [DW-1:0]   din_q, din_d;
    logic [SW-1:0]   result_q, result_d;
    logic [r-1:0]    ack_q, ack_d;
    logic [r-1:0]    err_q, err_d;
    logic            pl_q, pl_d;
    logic            busy_q, busy_d;

    logic            any_req_s;
    logic [GW-1:0]   sel_s;
    logic            timeout_s;
    logic [r-1:0]    grant_onehot_s;
    logic [GW-1:0]   next_ptr_s;

    // Index of the requester found 'off' steps after the priority pointer, modulo r.
    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] p, input int off);
        int t;
        t = (int'(p) + off) % r;
        return GW'(t);
    endfunction

    // One-hot decode of a requester index onto the r-bit ack/err vectors.
    function automatic logic [r-1:0] onehot(input logic [GW-1:0] idx);
        return r'(1'b1) << idx;
    endfunction

    assign any_req_s      = |req;
    assign grant_onehot_s = onehot(grant_q);
    assign next_ptr_s     = (grant_q == GW'(r - 1)) ? {GW{1'b0}} : grant_q + GW'(1);

    // Round-robin search: walk from ptr+r-1 down to ptr so the closest set bit to ptr wins.
    always_comb begin
        sel_s = ptr_q;
        for (int off = r - 1; off >= 0; off--) begin
            sel_s = req[rr_idx(ptr_q, off)] ? rr_idx(ptr_q, off) : sel_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, including the wait-phase timeout abort.
    always_comb begin
        state_d   = state_q;
        timeout_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req_s) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!acc_ready) begin
                    state_d = S_WAIT_HI;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = S_IDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_HI: begin
                if (acc_ready) begin
                    state_d = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = S_IDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_d = S_WAIT_HI;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values; pulses are keyed to the state being entered.
    always_comb begin
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        din_d    = din_q;
        result_d = result_q;
        ack_d    = {r{1'b0}};
        err_d    = {r{1'b0}};
        pl_d     = (state_d == S_LOAD);
        busy_d   = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (any_req_s) begin
                    grant_d = sel_s;
                    din_d   = req_data[int'(sel_s)*DW +: DW];
                end else begin
                    grant_d = grant_q;
                    din_d   = din_q;
                end
            end
            S_LOAD: begin
                cnt_d = {CW{1'b0}};
            end
            S_WAIT_LO: begin
                if (!acc_ready) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (timeout_s) begin
                    err_d = grant_onehot_s;
                    ptr_d = next_ptr_s;
                    cnt_d = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_HI: begin
                if (acc_ready) begin
                    result_d = acc_sum;
                    ack_d    = grant_onehot_s;
                end else if (timeout_s) begin
                    err_d = grant_onehot_s;
                    ptr_d = next_ptr_s;
                    cnt_d = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                ptr_d = next_ptr_s;
            end
            default: begin
                cnt_d = {CW{1'b0}};
            end
        endcase
    end

    // Datapath and output registers; a mid-job reset simply drops the job.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= {CW{1'b0}};
            ptr_q    <= {GW{1'b0}};
            grant_q  <= {GW{1'b0}};
            din_q    <= {DW{1'b0}};
            result_q <= {SW{1'b0}};
            ack_q    <= {r{1'b0}};
            err_q    <= {r{1'b0}};
            pl_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            din_q    <= din_d;
            result_q <= result_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            pl_q     <= pl_d;
            busy_q   <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign err      = err_q;
    assign result   = result_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;
    assign acc_din  = din_q;
    assign acc_pl   = pl_q;

endmodule
